// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared widths, ALU operation codes and requester IDs for the ALU arbiter.
package alu_arbiter_pkg;

    localparam int LEN_DATA_DEF     = 64;
    localparam int LEN_TYPE_ALU_DEF = 4;
    localparam int MAX_INFLIGHT_DEF = 4;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_SRA  = 4'd8,
        ALU_SLT  = 4'd9,
        ALU_SLTU = 4'd10,
        ALU_MUL  = 4'd11,
        ALU_NOT  = 4'd12,
        ALU_PASS = 4'd13
    } alu_op_e;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_e;

    function automatic req_id_e other(input req_id_e id);
        return (id == REQ0) ? REQ1 : REQ0;
    endfunction

endpackage

// File: rtl/alu_tag_fifo.sv
// alu_tag_fifo: in-order FIFO of 1-bit requester tags, DEPTH a power of two, with occupancy count.
module alu_tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   din,
    output logic                   dout,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;

    assign dout = mem[rptr];

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= din;
    end

    // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop) rptr <= rptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for one shared pipelined ALU with in-order retirement.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int LEN_DATA     = LEN_DATA_DEF,
    parameter int LEN_TYPE_ALU = LEN_TYPE_ALU_DEF,
    parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [LEN_DATA-1:0]     req0_a,
    input  logic [LEN_DATA-1:0]     req0_b,
    input  logic [LEN_TYPE_ALU-1:0] req0_code,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [LEN_DATA-1:0]     req1_a,
    input  logic [LEN_DATA-1:0]     req1_b,
    input  logic [LEN_TYPE_ALU-1:0] req1_code,
    output logic                    resp0_valid,
    output logic [LEN_DATA-1:0]     resp0_result,
    output logic                    resp0_cout,
    output logic                    resp1_valid,
    output logic [LEN_DATA-1:0]     resp1_result,
    output logic                    resp1_cout,
    output logic                    alu_en,
    output logic [LEN_DATA-1:0]     alu_a,
    output logic [LEN_DATA-1:0]     alu_b,
    output logic [LEN_TYPE_ALU-1:0] alu_code,
    input  logic [LEN_DATA-1:0]     alu_result,
    input  logic                    alu_cout,
    input  logic                    alu_rdy,
    output logic                    err
);

    localparam int CW = $clog2(MAX_INFLIGHT) + 1;

    logic [CW-1:0] count;
    req_id_e       gid;
    logic          tag;
    logic          fire;
    logic          pop;
    logic          empty;
    logic          room;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    req_id_e prio;

    assign gid = (req0_valid && req1_valid) ? prio : (req0_valid ? REQ0 : REQ1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) prio <= REQ0;
        else if (fire) prio <= other(gid);
    end
`else
    assign gid = req0_valid ? REQ0 : REQ1;
`endif

    // A retire in the same cycle frees a slot, so a full FIFO can still accept.
    assign empty = (count == '0);
    assign room  = (count != CW'(MAX_INFLIGHT)) || alu_rdy;
    assign fire  = rst && (req0_valid || req1_valid) && room;
    assign pop   = alu_rdy && !empty;

    assign req0_ready = fire && (gid == REQ0);
    assign req1_ready = fire && (gid == REQ1);
    assign alu_en     = fire;
    assign alu_a      = fire ? ((gid == REQ0) ? req0_a : req1_a) : '0;
    assign alu_b      = fire ? ((gid == REQ0) ? req0_b : req1_b) : '0;
    assign alu_code   = fire ? ((gid == REQ0) ? req0_code : req1_code) : '0;

    alu_tag_fifo #(
        .DEPTH (MAX_INFLIGHT)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fire),
        .pop   (pop),
        .din   (gid == REQ1),
        .dout  (tag),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp0_valid  <= 1'b0;
            resp0_result <= '0;
            resp0_cout   <= 1'b0;
            resp1_valid  <= 1'b0;
            resp1_result <= '0;
            resp1_cout   <= 1'b0;
            err          <= 1'b0;
        end else begin
            resp0_valid <= pop && !tag;
            resp1_valid <= pop && tag;
            if (pop && !tag) begin
                resp0_result <= alu_result;
                resp0_cout   <= alu_cout;
            end
            if (pop && tag) begin
                resp1_result <= alu_result;
                resp1_cout   <= alu_cout;
            end
            if (alu_rdy && empty) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random stimulus against a queue-based model of the arbiter and its ALU.
module tb_alu_arbiter;

    localparam int W = 64;
    localparam int C = 4;
    localparam int M = 4;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_ready, req1_ready;
    logic         resp0_valid, resp0_cout, resp1_valid, resp1_cout;
    logic [W-1:0] resp0_result, resp1_result;
    logic         alu_en;
    logic [W-1:0] alu_a, alu_b;
    logic [C-1:0] alu_code;
    logic [W-1:0] alu_result = '0;
    logic         alu_cout = 1'b0;
    logic         alu_rdy = 1'b0;
    logic         err;

    logic         rv[2];
    logic [W-1:0] ra[2];
    logic [W-1:0] rb[2];
    logic [C-1:0] rc[2];

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (rv[0]),
        .req0_ready   (req0_ready),
        .req0_a       (ra[0]),
        .req0_b       (rb[0]),
        .req0_code    (rc[0]),
        .req1_valid   (rv[1]),
        .req1_ready   (req1_ready),
        .req1_a       (ra[1]),
        .req1_b       (rb[1]),
        .req1_code    (rc[1]),
        .resp0_valid  (resp0_valid),
        .resp0_result (resp0_result),
        .resp0_cout   (resp0_cout),
        .resp1_valid  (resp1_valid),
        .resp1_result (resp1_result),
        .resp1_cout   (resp1_cout),
        .alu_en       (alu_en),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_code     (alu_code),
        .alu_result   (alu_result),
        .alu_cout     (alu_cout),
        .alu_rdy      (alu_rdy),
        .err          (err)
    );

    typedef struct {
        bit           id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [C-1:0] code;
        int           due;
    } op_t;

    op_t          ops[$];
    int           n_pass = 0;
    int           n_tot = 0;
    int           cyc = 0;
    int           lat_lo = 2;
    int           lat_hi = 2;
    bit           hold = 0;
    bit           spur = 0;
    bit           prio = 0;
    logic         exp_rv[2];
    logic [W-1:0] exp_res[2];
    logic         exp_cout[2];
    logic         exp_err = 1'b0;

    function automatic logic [W:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [C-1:0] code);
        return (code == 4'd1) ? ({1'b0, a} + {1'b0, b}) : {1'b0, a ^ b};
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic refresh(input bit n);
        ra[n] = {$urandom, $urandom};
        rb[n] = {$urandom, $urandom};
        rc[n] = C'($urandom_range(1, 13));
    endtask

    task automatic model_reset();
        ops.delete();
        prio = 0;
        exp_err = 1'b0;
        for (int n = 0; n < 2; n++) begin
            exp_rv[n] = 1'b0;
            exp_res[n] = '0;
            exp_cout[n] = 1'b0;
        end
    endtask

    // One clock: drive the ALU side, check all outputs, then advance the model at the edge.
    task automatic cycle();
        bit         g, room, fire;
        logic [W:0] r;
        op_t        f;
        if (spur) begin
            alu_rdy = 1'b1;
            alu_result = {$urandom, $urandom};
            alu_cout = 1'($urandom);
        end else if (!hold && ops.size() > 0 && ops[0].due <= cyc) begin
            r = alu_fn(ops[0].a, ops[0].b, ops[0].code);
            alu_rdy = 1'b1;
            alu_result = r[W-1:0];
            alu_cout = r[W];
        end else begin
            alu_rdy = 1'b0;
            alu_result = {$urandom, $urandom};
            alu_cout = 1'b0;
        end
        #1;
        g = (rv[0] && rv[1]) ? (RR ? prio : 1'b0) : !rv[0];
        room = (ops.size() < M) || alu_rdy;
        fire = (rv[0] || rv[1]) && room;
        chk("ready0", req0_ready, fire && !g);
        chk("ready1", req1_ready, fire && g);
        chk("alu_en", alu_en, fire);
        if (fire) begin
            chk("alu_a", alu_a, ra[g]);
            chk("alu_b", alu_b, rb[g]);
            chk("alu_code", alu_code, rc[g]);
        end
        chk("resp0_valid", resp0_valid, exp_rv[0]);
        chk("resp0_result", resp0_result, exp_res[0]);
        chk("resp0_cout", resp0_cout, exp_cout[0]);
        chk("resp1_valid", resp1_valid, exp_rv[1]);
        chk("resp1_result", resp1_result, exp_res[1]);
        chk("resp1_cout", resp1_cout, exp_cout[1]);
        chk("err", err, exp_err);
        @(posedge clk);
        exp_rv[0] = 1'b0;
        exp_rv[1] = 1'b0;
        if (alu_rdy) begin
            if (ops.size() > 0) begin
                f = ops.pop_front();
                r = alu_fn(f.a, f.b, f.code);
                exp_rv[f.id] = 1'b1;
                exp_res[f.id] = r[W-1:0];
                exp_cout[f.id] = r[W];
            end else begin
                exp_err = 1'b1;
            end
        end
        if (fire) begin
            ops.push_back('{g, ra[g], rb[g], rc[g], cyc + $urandom_range(lat_lo, lat_hi)});
            prio = !g;
        end
        cyc++;
        @(negedge clk);
        if (fire) refresh(g);
    endtask

    task automatic drain();
        rv[0] = 1'b0;
        rv[1] = 1'b0;
        hold = 0;
        repeat (8) cycle();
    endtask

    initial begin
        rv[0] = 1'b0;
        rv[1] = 1'b0;
        refresh(0);
        refresh(1);
        model_reset();
        #2 rst = 1'b0;
        #1;
        chk("rst_ready0", req0_ready, 1'b0);
        chk("rst_alu_en", alu_en, 1'b0);
        chk("rst_resp0_valid", resp0_valid, 1'b0);
        chk("rst_resp1_result", resp1_result, '0);
        chk("rst_err", err, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Both requesters valid for four cycles with ALU latency 2.
        ra[0] = 64'd5;
        rb[0] = 64'd7;
        rc[0] = 4'd1;
        rc[1] = 4'd1;
        rv[0] = 1'b1;
        rv[1] = 1'b1;
        repeat (4) cycle();
        drain();

        // ALU stalled: four accepted, fifth waits for the first retire.
        hold = 1;
        rv[0] = 1'b1;
        repeat (6) cycle();
        hold = 0;
        cycle();
        drain();

        // Carry-out on all-ones plus one, routed to requester 1.
        ra[1] = '1;
        rb[1] = 64'd1;
        rc[1] = 4'd1;
        rv[1] = 1'b1;
        cycle();
        drain();
        chk("ovf_result", resp1_result, '0);
        chk("ovf_cout", resp1_cout, 1'b1);

        // Retire with nothing in flight sets a sticky error.
        spur = 1;
        cycle();
        spur = 0;
        repeat (3) cycle();

        // Random traffic with variable latency and ALU stalls.
        lat_lo = 1;
        lat_hi = 3;
        repeat (300) begin
            rv[0] = 1'($urandom);
            rv[1] = 1'($urandom);
            hold = ($urandom_range(0, 3) == 0);
            cycle();
        end
        lat_lo = 2;
        lat_hi = 2;
        drain();

        // Reset with three operations in flight.
        hold = 1;
        rv[0] = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
        #1;
        chk("mid_rst_ready0", req0_ready, 1'b0);
        chk("mid_rst_alu_en", alu_en, 1'b0);
        chk("mid_rst_alu_a", alu_a, '0);
        chk("mid_rst_alu_code", alu_code, '0);
        chk("mid_rst_resp0_result", resp0_result, '0);
        chk("mid_rst_resp1_result", resp1_result, '0);
        chk("mid_rst_err", err, 1'b0);
        model_reset();
        hold = 0;
        @(negedge clk);
        rst = 1'b1;
        cycle();
        hold = 1;
        repeat (5) cycle();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter LEN_DATA, default 64, operand/result width.
REQ-002 SHALL have parameter LEN_TYPE_ALU, default 4, operation code width.
REQ-003 SHALL have parameter MAX_INFLIGHT, default 4, power of two, maximum outstanding ALU operations.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports reqN_valid / reqN_ready  input / output  1  request handshake per requester, N = 0,1.
REQ-007 SHALL have ports reqN_a, reqN_b  input  LEN_DATA  operands.
REQ-008 SHALL have port reqN_code  input  LEN_TYPE_ALU  operation code.
REQ-009 SHALL have ports respN_valid  output  1, respN_result  output  LEN_DATA, respN_cout  output  1  one-cycle response pulse.
REQ-010 SHALL have ports alu_en  output  1, alu_a / alu_b  output  LEN_DATA, alu_code  output  LEN_TYPE_ALU  issue to shared ALU.
REQ-011 SHALL have ports alu_result  input  LEN_DATA, alu_cout  input  1, alu_rdy  input  1  ALU completion, in issue order.
REQ-012 SHALL have port err  output  1  sticky protocol error.

Function
REQ-013 SHALL grant at most one requester per cycle; transfer occurs when reqN_valid && reqN_ready.
REQ-014 SHALL assert reqN_ready only for the granted requester, and only when inflight count < MAX_INFLIGHT or a retire (alu_rdy) occurs the same cycle.
REQ-015 SHALL drive alu_en high, with the granted operands/code, in the same cycle as the transfer; ALU outputs SHALL be registered-free pass-through (zero added latency).
REQ-016 SHALL push the granted requester ID into an in-order tag FIFO on each issue.
REQ-017 SHALL, on alu_rdy, pop the tag FIFO and pulse respN_valid for the popped ID in the next cycle, with registered alu_result/alu_cout.
REQ-018 SHALL keep inflight count = FIFO occupancy; simultaneous push and pop leaves count unchanged.
REQ-019 SHALL set err and discard the event when alu_rdy arrives with empty FIFO; err clears only on reset.
REQ-020 SHALL hold respN_valid low, respN_result/respN_cout at last values, when no retire occurs.
REQ-021 SHALL wrap FIFO pointers modulo MAX_INFLIGHT; full blocks grant, empty blocks nothing.
REQ-022 SHALL not require responses to be back-pressured; requesters always accept respN_valid.

Reset
REQ-023 SHALL, on rst low, asynchronously clear: reqN_ready, respN_valid, respN_result, respN_cout, alu_en, alu_a, alu_b, alu_code, err to 0; FIFO pointers, count, priority pointer to 0.
REQ-024 SHALL discard all in-flight operations on reset; alu_rdy results from before reset are treated as REQ-019 if FIFO empty.

Configuration
REQ-025 SHALL, with ALU_ARB_ROUND_ROBIN_EN defined, arbitrate round-robin: after a grant to N, requester 1-N has priority next cycle.
REQ-026 SHALL, without ALU_ARB_ROUND_ROBIN_EN, use fixed priority: requester 0 always wins when both valid.

Structure
REQ-027 SHALL take LEN_DATA, LEN_TYPE_ALU and operation code constants (1..13) from the shared define file main.def.v.
REQ-028 SHALL place the tag FIFO in one sub-module, alu_tag_fifo (width 1, depth MAX_INFLIGHT, count output).
REQ-029 SHALL contain no arithmetic; all computation stays in the ALU.

Verification
REQ-030 Both valid, round-robin on, 4 cycles, ALU latency 2 -> grants 0,1,0,1; responses to 0,1,0,1 with A+B correct (e.g. 5+7=12).
REQ-031 Same stimulus, macro off -> all 4 grants to requester 0, requester 1 stalled (ready low).
REQ-032 ALU rdy held off, requester 0 issues 5 ops -> 4 accepted, ready low on 5th until first alu_rdy, then accepted in that same cycle.
REQ-033 alu_rdy pulse with FIFO empty -> err=1, no respN_valid, err persists until rst low.
REQ-034 rst asserted with 3 in flight -> all outputs 0 immediately; after release, count=0 and a new request issues next cycle.
REQ-035 Issue of 0xFFFF_FFFF_FFFF_FFFF + 1 code 1 -> resp result 0, cout 1 to correct requester.
